// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execute unit (add/sub/compare/logic/shift, optional shift-add multiply).
// Latency: 1 cycle for single-cycle ops; XLEN cycles for MUL (ALU_EXEC_MUL_EN only).
// Backpressure: in_ready drops while a result is stalled (out_valid && !out_ready) or a multiply is iterating.
//
// Optional feature macro: ALU_EXEC_MUL_EN (adds the iterative MUL state, counter and partial product).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake
//   alu_op, funct3, funct7, op5   operation encoding
//   src_a, src_b           operands (XLEN)
//   out_valid / out_ready  result handshake
//   result, zero, illegal  registered result, result==0 flag, unsupported-encoding flag
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] dec_res;
  logic            dec_ill;
  logic            accept;
  logic            load_vld;
  logic [XLEN-1:0] load_res;
  logic            load_ill;

  assign shamt  = src_b[SHW-1:0];
  assign accept = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  logic dec_mul;
`endif

  // Combinational decode and evaluation of the single-cycle operations.
  always_comb begin
    dec_res = '0;
    dec_ill = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    dec_mul = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_res = src_a + src_b;
      2'b01: dec_res = src_a - src_b;
      2'b10: begin
        // Only R-type carries a real funct7; for I-type those bits are immediate.
        if (op5 && (funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
`ifdef ALU_EXEC_MUL_EN
          if ((funct7 == F7_MULDIV) && (funct3 == 3'b000)) dec_mul = 1'b1;
          else                                              dec_ill = 1'b1;
`else
          dec_ill = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000: dec_res = (op5 && funct7[5]) ? (src_a - src_b) : (src_a + src_b);
            3'b001: dec_res = src_a << shamt;
            3'b010: dec_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b011: dec_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            3'b100: dec_res = src_a ^ src_b;
            3'b101: dec_res = funct7[5] ? XLEN'($signed(src_a) >>> shamt) : (src_a >> shamt);
            3'b110: dec_res = src_a | src_b;
            default: dec_res = src_a & src_b;
          endcase
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mul_sum;
  logic            mul_done;

  // One multiplier bit per cycle: add the shifted multiplicand when the current bit is set.
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == S_MUL) && (cnt == SHW'(XLEN-1));
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && dec_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_done)          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if ((state == S_IDLE) && accept && dec_mul) begin
      cnt    <= '0;
      mcand  <= src_a;
      mplier <= src_b;
      acc    <= '0;
    end else if (state == S_MUL) begin
      cnt    <= cnt + SHW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= mul_sum;
    end
  end

  // The final iteration's sum goes straight to the result register.
  assign load_vld = (accept && !dec_mul) || mul_done;
  assign load_res = mul_done ? mul_sum : dec_res;
  assign load_ill = mul_done ? 1'b0 : dec_ill;
`else
  assign in_ready = !out_valid || out_ready;
  assign load_vld = accept;
  assign load_res = dec_res;
  assign load_ill = dec_ill;
`endif

  // Output register: a new load wins over a same-cycle drain, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_vld) begin
      out_valid <= 1'b1;
      result    <= load_res;
      zero      <= (load_res == '0);
      illegal   <= load_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic o5, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op5      = o5;
    src_a    = a;
    src_b    = b;
  endtask

  // Issue one op, clock it in, and check the registered outputs one edge later.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic o5, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
    issue(op, f3, f7, o5, a, b);
    tick();
    check({tag, "_vld"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'h0));
    check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
  endtask

  initial begin
    int busy;
    int early;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; op5 = 1'b0;
    src_a = 32'h0; src_b = 32'h0;
    #12;
    check("rst_vld", 64'(out_valid), 64'(1'b0));
    check("rst_res", 64'(result), 64'h0);
    check("rst_zero", 64'(zero), 64'(1'b0));
    check("rst_ill", 64'(illegal), 64'(1'b0));
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 64'(in_ready), 64'(1'b1));
    tick();
    check("idle_vld", 64'(out_valid), 64'(1'b0));

    // Directed single-cycle ops, back to back with out_ready=1.
    run_op("sub",  2'b10, 3'b000, 7'h20, 1'b1, 32'h5,        32'h7,        32'hFFFF_FFFE, 1'b0);
    run_op("sra",  2'b10, 3'b101, 7'h20, 1'b1, 32'h8000_0000, 32'h24,       32'hF800_0000, 1'b0);
    run_op("srl",  2'b10, 3'b101, 7'h00, 1'b1, 32'h8000_0000, 32'h24,       32'h0800_0000, 1'b0);
    run_op("slli", 2'b10, 3'b001, 7'h00, 1'b0, 32'h1,        32'h25,       32'h0000_0020, 1'b0);
    run_op("slt",  2'b10, 3'b010, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'h1,        32'h1,         1'b0);
    run_op("sltu", 2'b10, 3'b011, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0);
    run_op("xor",  2'b10, 3'b100, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    run_op("or",   2'b10, 3'b110, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    run_op("and",  2'b10, 3'b111, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    run_op("addw", 2'b00, 3'b000, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'h2,        32'h1,         1'b0);
    run_op("addi", 2'b10, 3'b000, 7'h20, 1'b0, 32'hA,        32'h3,        32'hD,         1'b0);
    run_op("rsvd", 2'b11, 3'b000, 7'h00, 1'b0, 32'h1234,     32'h5678,     32'h0,         1'b1);
    run_op("cmpeq",2'b01, 3'b000, 7'h00, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0,        1'b0);
    run_op("badf7",2'b10, 3'b000, 7'h02, 1'b1, 32'h3,        32'h4,        32'h0,         1'b1);
    in_valid = 1'b0;
    tick();
    check("drain_vld", 64'(out_valid), 64'(1'b0));

    // Backpressure: four adds, consumer stalls after the first.
    issue(2'b00, 3'b000, 7'h00, 1'b0, 32'h1, 32'h100);
    tick();
    out_ready = 1'b0;
    issue(2'b00, 3'b000, 7'h00, 1'b0, 32'h2, 32'h100);
    #1;
    check("bp_res1", 64'(result), 64'h101);
    check("bp_rdy0", 64'(in_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_res", 64'(result), 64'h101);
      check("bp_hold_vld", 64'(out_valid), 64'(1'b1));
      check("bp_hold_rdy", 64'(in_ready), 64'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy1", 64'(in_ready), 64'(1'b1));
    tick();
    check("bp_res2", 64'(result), 64'h102);
    issue(2'b00, 3'b000, 7'h00, 1'b0, 32'h3, 32'h100);
    tick();
    check("bp_res3", 64'(result), 64'h103);
    check("bp_vld3", 64'(out_valid), 64'(1'b1));
    issue(2'b00, 3'b000, 7'h00, 1'b0, 32'h4, 32'h100);
    tick();
    check("bp_res4", 64'(result), 64'h104);
    check("bp_vld4", 64'(out_valid), 64'(1'b1));
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'(1'b0));

`ifdef ALU_EXEC_MUL_EN
    // Iterative multiply: result lands exactly 32 edges after acceptance.
    issue(2'b10, 3'b000, 7'h01, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
    tick();
    in_valid = 1'b0;
    busy = 0; early = 0;
    for (int i = 1; i < 32; i++) begin
      if (!in_ready) busy++;
      if (out_valid) early++;
      tick();
    end
    check("mul_busy", 64'(busy), 64'd31);
    check("mul_early", 64'(early), 64'd0);
    check("mul_vld", 64'(out_valid), 64'(1'b1));
    check("mul_res", 64'(result), 64'hFFFF_FFFF);
    check("mul_ill", 64'(illegal), 64'(1'b0));
    tick();
    check("mul_drain", 64'(out_valid), 64'(1'b0));

    // Reset mid-multiply abandons the operation.
    issue(2'b10, 3'b000, 7'h01, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #2;
    check("mulrst_vld", 64'(out_valid), 64'(1'b0));
    rst_n = 1'b1;
    #1;
    check("mulrst_rdy", 64'(in_ready), 64'(1'b1));
    early = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) early++;
    end
    check("mulrst_novld", 64'(early), 64'd0);
`else
    busy = 0; early = 0;
    run_op("mul_ill", 2'b10, 3'b000, 7'h01, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("mul_ill_drain", 64'(out_valid), 64'(1'b0));
    check("mul_ill_cnt", 64'(busy + early), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
